// File: rtl/io_port_master.sv
// Command-driven master for a strobed 8-bit I/O port bus with interrupt acknowledge.
// Each command runs SETUP then STROBE; interrupt requests win over commands while idle.
module io_port_master #(
    parameter int unsigned ACK_IRQ = 1
) (
    input  logic       sysclk,
    input  logic       sysreset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_port,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic [7:0] in_port,
    input  logic       interrupt,
    output logic       interrupt_ack,
    output logic       irq_event
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        ACK
    } state_t;

    state_t state;
    logic   guard;
    logic   write_q;
    logic   irq_take;

    // guard masks the request for the one cycle after an ack so a slow-clearing peripheral is not acked twice
    assign irq_take  = (ACK_IRQ != 0) && interrupt && !guard;
    assign cmd_ready = (state == IDLE) && !irq_take;

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            state         <= IDLE;
            guard         <= 1'b0;
            write_q       <= 1'b0;
            port_id       <= '0;
            out_port      <= '0;
            write_strobe  <= 1'b0;
            read_strobe   <= 1'b0;
            interrupt_ack <= 1'b0;
            irq_event     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
        end else begin
            write_strobe  <= 1'b0;
            read_strobe   <= 1'b0;
            rsp_valid     <= 1'b0;
            interrupt_ack <= 1'b0;
            irq_event     <= 1'b0;
            guard         <= 1'b0;
            case (state)
                IDLE: begin
                    if (irq_take) begin
                        state         <= ACK;
                        interrupt_ack <= 1'b1;
                        irq_event     <= 1'b1;
                    end else if (cmd_valid) begin
                        state   <= SETUP;
                        port_id <= cmd_port;
                        write_q <= cmd_write;
                        if (cmd_write) begin
                            out_port <= cmd_wdata;
                        end
                    end
                end
                SETUP: begin
                    state        <= STROBE;
                    write_strobe <= write_q;
                    read_strobe  <= !write_q;
                end
                STROBE: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                    if (!write_q) begin
                        rsp_rdata <= in_port;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    guard <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
